// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Memory controller between the L1 caches and main_mem.
//             Arbitrates icache (read-only) and dcache (read/write) block
//             requests onto the single registered main_mem request port and
//             routes each main_mem response back to the issuing cache.
//             Outstanding requests are counted per client; the dcache request
//             type is kept in an in-order FIFO so each dcache response carries
//             a write/read flag.
//  Macro    : MEM_CTRL_RR_ARB_EN - round-robin tie-break between the clients.
//             Undefined: fixed priority, dcache wins ties.
//  Ports    : clk, rst_aL (sync, active-low)
//             ic_req_*  / ic_resp_*  : icache request / response
//             dc_req_*  / dc_resp_*  : dcache request / response
//             mm_req_*  (registered) : request to main_mem
//             mm_resp_*              : response from main_mem
//             err_unexpected_resp    : sticky, response with nothing in flight
//  Revision : 1.0 - initial release
// ============================================================================

package mem_ctrl_pkg;
  localparam int BLOCK_ADDR_W = 8;
  localparam int BLOCK_DATA_W = 64;

  typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_W-1:0] block_data_t;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_type_t;
endpackage

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst_aL,

  input  logic                 ic_req_valid,
  output logic                 ic_req_ready,
  input  main_mem_block_addr_t ic_req_block_addr,
  output logic                 ic_resp_valid,
  output block_data_t          ic_resp_block_data,

  input  logic                 dc_req_valid,
  output logic                 dc_req_ready,
  input  req_type_t            dc_req_type,
  input  main_mem_block_addr_t dc_req_block_addr,
  input  block_data_t          dc_req_block_data,
  output logic                 dc_resp_valid,
  output logic                 dc_resp_is_write,
  output block_data_t          dc_resp_block_data,

  output logic                 mm_req_valid,
  output cache_type_t          mm_req_cache_type,
  output req_type_t            mm_req_type,
  output main_mem_block_addr_t mm_req_block_addr,
  output block_data_t          mm_req_block_data,
  input  logic                 mm_resp_valid,
  input  cache_type_t          mm_resp_cache_type,
  input  block_data_t          mm_resp_block_data,

  output logic                 err_unexpected_resp
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0]           ic_cnt;
  logic [CNT_W-1:0]           dc_cnt;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [MAX_OUTSTANDING-1:0] type_fifo;   // 1 = WRITE
  cache_type_t                last_grant;

  logic ic_elig, dc_elig, dc_wins_tie;
  logic grant_ic, grant_dc;
  logic resp_ic, resp_dc;
  logic ic_pop, dc_pop;
  logic unexpected;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Arbitration. Eligibility uses the registered counters only, so a response
  // retiring this cycle cannot free a slot for a same-cycle accept.
  // --------------------------------------------------------------------------
  always_comb begin
    ic_elig = rst_aL && ic_req_valid && (ic_cnt < CNT_MAX);
    dc_elig = rst_aL && dc_req_valid && (dc_cnt < CNT_MAX);
`ifdef MEM_CTRL_RR_ARB_EN
    dc_wins_tie = (last_grant == ICACHE);
`else
    dc_wins_tie = 1'b1;
`endif
    grant_dc = dc_elig && (!ic_elig || dc_wins_tie);
    grant_ic = ic_elig && !grant_dc;
  end

  assign ic_req_ready = grant_ic;
  assign dc_req_ready = grant_dc;

  // --------------------------------------------------------------------------
  // Response routing. A response for a client with nothing outstanding is
  // still forwarded but does not touch the counter or the FIFO.
  // --------------------------------------------------------------------------
  always_comb begin
    resp_ic    = mm_resp_valid && (mm_resp_cache_type == ICACHE);
    resp_dc    = mm_resp_valid && (mm_resp_cache_type == DCACHE);
    ic_pop     = resp_ic && (ic_cnt != '0);
    dc_pop     = resp_dc && (dc_cnt != '0);
    unexpected = (resp_ic && (ic_cnt == '0)) || (resp_dc && (dc_cnt == '0));
  end

  assign ic_resp_valid      = resp_ic;
  assign ic_resp_block_data = resp_ic ? mm_resp_block_data : '0;
  assign dc_resp_valid      = resp_dc;
  assign dc_resp_block_data = resp_dc ? mm_resp_block_data : '0;
  assign dc_resp_is_write   = dc_pop ? type_fifo[rd_ptr] : 1'b0;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      ic_cnt              <= '0;
      dc_cnt              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      last_grant          <= ICACHE;
      err_unexpected_resp <= 1'b0;
    end else begin
      // Accept and retire in the same cycle cancel out.
      ic_cnt     <= ic_cnt + CNT_W'(grant_ic) - CNT_W'(ic_pop);
      dc_cnt     <= dc_cnt + CNT_W'(grant_dc) - CNT_W'(dc_pop);
      wr_ptr     <= grant_dc ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr     <= dc_pop   ? ptr_inc(rd_ptr) : rd_ptr;
      last_grant <= grant_dc ? DCACHE : (grant_ic ? ICACHE : last_grant);
      if (unexpected) begin
        err_unexpected_resp <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: entries are only read behind a valid push.
  always_ff @(posedge clk) begin
    if (grant_dc) begin
      type_fifo[wr_ptr] <= (dc_req_type == WRITE);
    end
  end

  // --------------------------------------------------------------------------
  // Registered main_mem request; zeroed whenever nothing is accepted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_aL || !(grant_ic || grant_dc)) begin
      mm_req_valid      <= 1'b0;
      mm_req_cache_type <= ICACHE;
      mm_req_type       <= READ;
      mm_req_block_addr <= '0;
      mm_req_block_data <= '0;
    end else if (grant_ic) begin
      mm_req_valid      <= 1'b1;
      mm_req_cache_type <= ICACHE;
      mm_req_type       <= READ;
      mm_req_block_addr <= ic_req_block_addr;
      mm_req_block_data <= '0;
    end else begin
      mm_req_valid      <= 1'b1;
      mm_req_cache_type <= DCACHE;
      mm_req_type       <= dc_req_type;
      mm_req_block_addr <= dc_req_block_addr;
      mm_req_block_data <= dc_req_block_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench for mem_ctrl. Contains a main_mem stand-in
//             (fixed delay, in-order) and a transaction-level reference model
//             of the controller that is compared against the DUT every cycle,
//             plus directed scenarios with literal expectations.
//  Macro    : MEM_CTRL_RR_ARB_EN selects the expected arbitration order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int MAXO    = 4;
  localparam int N_DELAY = 5;
`ifdef MEM_CTRL_RR_ARB_EN
  localparam logic [7:0] EXP_ARB = 8'h55;   // D,I,D,I,...  (bit0 = first)
`else
  localparam logic [7:0] EXP_ARB = 8'h0F;   // D,D,D,D,I,I,I,I
`endif

  logic                 clk;
  logic                 rst_aL;
  logic                 ic_req_valid, ic_req_ready;
  main_mem_block_addr_t ic_req_block_addr;
  logic                 ic_resp_valid;
  block_data_t          ic_resp_block_data;
  logic                 dc_req_valid, dc_req_ready;
  req_type_t            dc_req_type;
  main_mem_block_addr_t dc_req_block_addr;
  block_data_t          dc_req_block_data;
  logic                 dc_resp_valid, dc_resp_is_write;
  block_data_t          dc_resp_block_data;
  logic                 mm_req_valid;
  cache_type_t          mm_req_cache_type;
  req_type_t            mm_req_type;
  main_mem_block_addr_t mm_req_block_addr;
  block_data_t          mm_req_block_data;
  logic                 mm_resp_valid;
  cache_type_t          mm_resp_cache_type;
  block_data_t          mm_resp_block_data;
  logic                 err_unexpected_resp;

  mem_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk                 (clk),
    .rst_aL              (rst_aL),
    .ic_req_valid        (ic_req_valid),
    .ic_req_ready        (ic_req_ready),
    .ic_req_block_addr   (ic_req_block_addr),
    .ic_resp_valid       (ic_resp_valid),
    .ic_resp_block_data  (ic_resp_block_data),
    .dc_req_valid        (dc_req_valid),
    .dc_req_ready        (dc_req_ready),
    .dc_req_type         (dc_req_type),
    .dc_req_block_addr   (dc_req_block_addr),
    .dc_req_block_data   (dc_req_block_data),
    .dc_resp_valid       (dc_resp_valid),
    .dc_resp_is_write    (dc_resp_is_write),
    .dc_resp_block_data  (dc_resp_block_data),
    .mm_req_valid        (mm_req_valid),
    .mm_req_cache_type   (mm_req_cache_type),
    .mm_req_type         (mm_req_type),
    .mm_req_block_addr   (mm_req_block_addr),
    .mm_req_block_data   (mm_req_block_data),
    .mm_resp_valid       (mm_resp_valid),
    .mm_resp_cache_type  (mm_resp_cache_type),
    .mm_resp_block_data  (mm_resp_block_data),
    .err_unexpected_resp (err_unexpected_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // main_mem stand-in: sampled at the negedge (same values the posedge sees),
  // response driven N_DELAY+1 cycles after the sampling cycle.
  // --------------------------------------------------------------------------
  typedef struct {
    int          due;
    cache_type_t c;
    block_data_t d;
  } pend_t;

  block_data_t mem [256];
  pend_t       pq[$];
  int          cyc = 0;

  task automatic step();
    pend_t p;
    @(negedge clk);
    if (!rst_aL) begin
      pq.delete();
    end else if (mm_req_valid === 1'b1) begin
      p.due = cyc + N_DELAY + 1;
      p.c   = mm_req_cache_type;
      p.d   = mem[mm_req_block_addr];
      if (mm_req_type == WRITE) mem[mm_req_block_addr] = mm_req_block_data;
      pq.push_back(p);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      mm_resp_valid      = 1'b1;
      mm_resp_cache_type = pq[0].c;
      mm_resp_block_data = pq[0].d;
      void'(pq.pop_front());
    end else begin
      mm_resp_valid      = 1'b0;
      mm_resp_cache_type = ICACHE;
      mm_resp_block_data = '0;
    end
  endtask

  task automatic drain();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    repeat (16) step();
  endtask

  // --------------------------------------------------------------------------
  // Reference model: counts, in-order type queue, last winner, sticky error.
  // Expected registered outputs are computed one negedge ahead.
  // --------------------------------------------------------------------------
  initial begin
    int          m_ic = 0, m_dc = 0;
    bit          m_q[$];
    bit          m_last = 1'b0;      // 0 = icache
    bit          m_err  = 1'b0;
    bit          have_exp = 1'b0;
    bit          e_valid, e_cache, e_type;
    logic [63:0] e_addr, e_data;
    bit          ie, de, gi, gd, tie_dc, ih, dh, e_wr;
    forever begin
      @(negedge clk);
      if (done) break;
      if (have_exp) begin
        chk("mm_req_valid", mm_req_valid, e_valid);
        chk("mm_req_cache_type", mm_req_cache_type, e_cache);
        chk("mm_req_type", mm_req_type, e_type);
        chk("mm_req_block_addr", mm_req_block_addr, e_addr);
        chk("mm_req_block_data", mm_req_block_data, e_data);
        chk("err_unexpected_resp", err_unexpected_resp, m_err);
      end
`ifdef MEM_CTRL_RR_ARB_EN
      tie_dc = (m_last == 1'b0);
`else
      tie_dc = 1'b1;
`endif
      ie = rst_aL && ic_req_valid && (m_ic < MAXO);
      de = rst_aL && dc_req_valid && (m_dc < MAXO);
      gd = de && (!ie || tie_dc);
      gi = ie && !gd;
      ih = mm_resp_valid && (mm_resp_cache_type == ICACHE);
      dh = mm_resp_valid && (mm_resp_cache_type == DCACHE);
      e_wr = (dh && m_dc > 0) ? m_q[0] : 1'b0;
      chk("ic_req_ready", ic_req_ready, gi);
      chk("dc_req_ready", dc_req_ready, gd);
      chk("ic_resp_valid", ic_resp_valid, ih);
      chk("ic_resp_block_data", ic_resp_block_data, ih ? mm_resp_block_data : 64'd0);
      chk("dc_resp_valid", dc_resp_valid, dh);
      chk("dc_resp_block_data", dc_resp_block_data, dh ? mm_resp_block_data : 64'd0);
      if (rst_aL) chk("dc_resp_is_write", dc_resp_is_write, e_wr);

      if (!rst_aL) begin
        m_ic = 0; m_dc = 0; m_q.delete(); m_last = 1'b0; m_err = 1'b0;
      end else begin
        if (ih) begin
          if (m_ic > 0) m_ic--; else m_err = 1'b1;
        end
        if (dh) begin
          if (m_dc > 0) begin m_dc--; void'(m_q.pop_front()); end
          else m_err = 1'b1;
        end
      end
      e_valid = 1'b0; e_cache = 1'b0; e_type = 1'b0; e_addr = '0; e_data = '0;
      if (gi) begin
        m_ic++; m_last = 1'b0;
        e_valid = 1'b1; e_addr = 64'(ic_req_block_addr);
      end else if (gd) begin
        m_dc++; m_last = 1'b1;
        m_q.push_back(dc_req_type == WRITE);
        e_valid = 1'b1; e_cache = 1'b1; e_type = (dc_req_type == WRITE);
        e_addr = 64'(dc_req_block_addr); e_data = dc_req_block_data;
      end
      have_exp = 1'b1;
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0] gv;
    logic [3:0] wv;
    int         na, nr;
    bit         found;

    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    rst_aL = 1'b0;
    ic_req_valid = 1'b0; ic_req_block_addr = '0;
    dc_req_valid = 1'b0; dc_req_type = READ; dc_req_block_addr = '0; dc_req_block_data = '0;
    mm_resp_valid = 1'b0; mm_resp_cache_type = ICACHE; mm_resp_block_data = '0;
    repeat (3) step();

    // Reset state: readies forced low even with both valids up.
    ic_req_valid = 1'b1; dc_req_valid = 1'b1;
    #1;
    chk("rst_ic_ready", ic_req_ready, 0);
    chk("rst_dc_ready", dc_req_ready, 0);
    chk("rst_mm_valid", mm_req_valid, 0);
    chk("rst_err", err_unexpected_resp, 0);
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    rst_aL = 1'b1;
    step();

    // Single WRITE to addr 3, then READ back.
    dc_req_valid = 1'b1; dc_req_type = WRITE; dc_req_block_addr = 8'd3;
    dc_req_block_data = {8{8'hA5}};
    #1 chk("wr_accept", dc_req_ready, 1);
    step();
    dc_req_valid = 1'b0;
    #1;
    chk("wr_mm_valid_t1", mm_req_valid, 1);
    chk("wr_mm_type", mm_req_type, WRITE);
    chk("wr_mm_addr", mm_req_block_addr, 3);
    chk("wr_mm_data", mm_req_block_data, {8{8'hA5}});
    repeat (5) step();
    #1 chk("wr_resp_t6", dc_resp_valid, 0);
    step();
    #1;
    chk("wr_resp_t7", dc_resp_valid, 1);
    chk("wr_resp_is_write", dc_resp_is_write, 1);

    dc_req_valid = 1'b1; dc_req_type = READ; dc_req_block_addr = 8'd3;
    dc_req_block_data = '0;
    #1 chk("rd_accept", dc_req_ready, 1);
    step();
    dc_req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      #1 if (dc_resp_valid) found = 1'b1;
    end
    chk("rd_resp_seen", found, 1);
    chk("rd_resp_data", dc_resp_block_data, {8{8'hA5}});
    chk("rd_resp_is_write", dc_resp_is_write, 0);
    drain();

    // Arbitration order from reset with both clients always requesting.
    rst_aL = 1'b0; step(); step(); rst_aL = 1'b1;
    gv = '0; na = 0;
    for (int k = 0; k < 20 && na < 8; k++) begin
      ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_type = READ;
      ic_req_block_addr = 8'($urandom); dc_req_block_addr = 8'($urandom);
      #1;
      if (dc_req_ready) begin gv[na] = 1'b1; na++; end
      else if (ic_req_ready) begin gv[na] = 1'b0; na++; end
      step();
    end
    chk("arb_accepts", na, 8);
    chk("arb_order", gv, EXP_ARB);
    drain();

    // dcache backpressure at MAX_OUTSTANDING, reassert one cycle after a response.
    dc_req_valid = 1'b1; dc_req_type = READ; dc_req_block_addr = 8'd7;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_accept", dc_req_ready, 1);
      step();
    end
    #1 chk("bp_full", dc_req_ready, 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      #1 if (dc_resp_valid) found = 1'b1;
    end
    chk("bp_resp_seen", found, 1);
    chk("bp_same_cycle", dc_req_ready, 0);
    step();
    #1 chk("bp_reassert", dc_req_ready, 1);
    drain();

    // Alternating READ/WRITE stream: is_write must come back 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      dc_req_valid = 1'b1; dc_req_type = (k % 2 == 1) ? WRITE : READ;
      dc_req_block_addr = 8'(k + 20); dc_req_block_data = {$urandom, $urandom};
      #1 chk("alt_accept", dc_req_ready, 1);
      step();
    end
    dc_req_valid = 1'b0;
    wv = '0; nr = 0;
    for (int k = 0; k < 20 && nr < 4; k++) begin
      #1 if (dc_resp_valid) begin wv[nr] = dc_resp_is_write; nr++; end
      step();
    end
    chk("alt_count", nr, 4);
    chk("alt_is_write", wv, 4'b1010);
    drain();

    // Unexpected dcache response with nothing in flight.
    mm_resp_valid = 1'b1; mm_resp_cache_type = DCACHE; mm_resp_block_data = 64'h1234;
    #1;
    chk("unexp_fwd_valid", dc_resp_valid, 1);
    chk("unexp_fwd_data", dc_resp_block_data, 64'h1234);
    chk("unexp_is_write", dc_resp_is_write, 0);
    step();
    #1 chk("unexp_err_set", err_unexpected_resp, 1);
    repeat (3) step();
    #1 chk("unexp_err_sticky", err_unexpected_resp, 1);
    na = 0;
    dc_req_valid = 1'b1; dc_req_type = READ;
    for (int k = 0; k < 6; k++) begin
      #1 if (dc_req_ready) na++;
      step();
    end
    chk("unexp_cnt_zero", na, 4);
    drain();

    // Reset with 3 requests in flight.
    dc_req_valid = 1'b1;
    repeat (3) step();
    dc_req_valid = 1'b0;
    rst_aL = 1'b0;
    step();
    rst_aL = 1'b1;
    #1;
    chk("rst_flight_mm_valid", mm_req_valid, 0);
    chk("rst_flight_err_clr", err_unexpected_resp, 0);
    nr = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      #1 if (dc_resp_valid || ic_resp_valid) nr++;
    end
    chk("rst_flight_no_resp", nr, 0);
    na = 0;
    dc_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 if (dc_req_ready) na++;
      step();
    end
    chk("rst_flight_cnt_zero", na, 4);
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      ic_req_valid      = ($urandom % 4) != 0;
      ic_req_block_addr = 8'($urandom_range(0, 15));
      dc_req_valid      = ($urandom % 3) != 0;
      dc_req_type       = ($urandom % 2) ? WRITE : READ;
      dc_req_block_addr = 8'($urandom_range(0, 15));
      dc_req_block_data = {$urandom, $urandom};
      step();
    end
    drain();

    done = 1'b1;
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the L1 caches and `main_mem`. Arbitrates icache (read-only) and dcache (read/write) block requests onto the single `main_mem` request port and routes each `main_mem` response back to the issuing cache. Tracks outstanding requests per client and buffers the dcache request type in order, so dcache responses carry a write/read flag. `main_mem` has no backpressure, so response ports have no ready.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: max in-flight requests per client (1..8).

Ports:
- `clk` in 1: sole clock.
- `rst_aL` in 1: reset, synchronous, active-low.
- `ic_req_valid` in 1: icache read request.
- `ic_req_ready` out 1: request accepted when `valid && ready` at posedge.
- `ic_req_block_addr` in `main_mem_block_addr_t`: block address.
- `ic_resp_valid` out 1: icache response.
- `ic_resp_block_data` out `block_data_t`: read data.
- `dc_req_valid` in 1: dcache request.
- `dc_req_ready` out 1: dcache accept.
- `dc_req_type` in `req_type_t`: READ/WRITE.
- `dc_req_block_addr` in `main_mem_block_addr_t`: block address.
- `dc_req_block_data` in `block_data_t`: write data.
- `dc_resp_valid` out 1: dcache response.
- `dc_resp_is_write` out 1: response belongs to a WRITE.
- `dc_resp_block_data` out `block_data_t`: read data (old contents on WRITE).
- `mm_req_valid`, `mm_req_cache_type`, `mm_req_type`, `mm_req_block_addr`, `mm_req_block_data` out: registered request to `main_mem`.
- `mm_resp_valid`, `mm_resp_cache_type`, `mm_resp_block_data` in: response from `main_mem`.
- `err_unexpected_resp` out 1: sticky; a response arrived for a client with zero outstanding.

## Operation
- Per-client counters `ic_cnt`, `dc_cnt` count 0..`MAX_OUTSTANDING`. The dcache type FIFO has depth `MAX_OUTSTANDING` and 1-bit entries.
- Eligibility: a client is eligible when `valid && cnt < MAX_OUTSTANDING`. No same-cycle bypass: a response popping in the cycle does not make a full client eligible.
- Grant:
  - At most one grant per cycle.
  - Single eligible client wins.
  - When both are eligible, the tie is broken by the arbitration policy (see Configuration).
  - `x_req_ready = grant_x`. Combinational from counters, `last_grant`, and both valids.
- Accept (icache): register the request into `mm_req_*` with `cache_type=ICACHE`, `req_type=READ`, data 0. `ic_cnt++`.
- Accept (dcache): register into `mm_req_*` with `cache_type=DCACHE`. `dc_cnt++`. Push `dc_req_type==WRITE` into the FIFO.
- No accept: `mm_req_valid<=0` and all other `mm_req_*` <= 0.
- `last_grant` register is updated on every accept.
- Response routing is combinational on `mm_resp_valid`:
  - ICACHE: `ic_resp_valid=1`, data passthrough, `ic_cnt--`.
  - DCACHE: `dc_resp_valid=1`, data passthrough, `dc_resp_is_write` = FIFO head, pop, `dc_cnt--`.
  - Idle response data outputs are 0.
- Accept and response for the same client in the same cycle: counter unchanged; FIFO pushes and pops together.
- Response for a client whose counter is 0:
  - Still forwarded; `dc_resp_is_write=0`.
  - Counter and FIFO are not modified (no underflow).
  - `err_unexpected_resp<=1`.

## Timing
- Reset (`rst_aL` low at posedge) clears:
  - all `mm_req_*` to 0;
  - `ic_cnt`, `dc_cnt`, FIFO pointers to 0;
  - `err_unexpected_resp` to 0;
  - `last_grant` to ICACHE.
- Combinational outputs during reset:
  - `ic_req_ready=0`, `dc_req_ready=0` (forced while `rst_aL` low).
  - Response outputs follow `mm_resp_*` (`main_mem` also resets to idle).
- Reset mid-operation: all in-flight requests are dropped. The shared `rst_aL` also clears the `main_mem` pipeline, so no stale responses arrive.
- Request latency: accept at posedge ending cycle t → `mm_req_valid` high in cycle t+1.
- Round trip with `main_mem` `N_DELAY_CYCLES`=N: response visible at the cache in cycle t+N+2.
- Responses per client are in order. Throughput: one accept per cycle total.

## Configuration
- `MEM_CTRL_RR_ARB_EN` defined: round-robin tie-break. The client not in `last_grant` wins.
- Undefined: fixed priority, dcache always wins ties. `last_grant` is still maintained but unused.

## Test plan
- Single dcache WRITE to addr 3, data 0xA5..A5, N=5 → `mm_req_valid` in cycle t+1, `dc_resp_valid` with `is_write=1` in cycle t+7. A following READ of addr 3 returns 0xA5..A5 with `is_write=0`.
- Both valid every cycle, 8 accepts from reset:
  - with `MEM_CTRL_RR_ARB_EN`: grants alternate D,I,D,I…;
  - without: all D until `dc_cnt`=4, then I.
- dcache issues 4 back-to-back requests (`MAX_OUTSTANDING`=4) with no responses yet → `dc_req_ready=0` on the fifth. It reasserts the cycle after the first response, not the same cycle.
- Alternating READ/WRITE/READ/WRITE dcache stream → `dc_resp_is_write` sequence 0,1,0,1 in order.
- Force `mm_resp_valid` with DCACHE while `dc_cnt`=0 → `dc_resp_valid=1`, `err_unexpected_resp` set and stays set until reset, `dc_cnt` remains 0.
- Reset asserted with 3 in flight → next cycle `mm_req_valid=0`, counters 0, no responses delivered afterwards.
